ex_mem_stage: RTL
=================

# ex_mem_stage

Pipeline stage register directly downstream of the execute-stage ALU. Captures the ALU result and flags with the instruction's memory/write-back control fields and store data, and resolves conditional branches from the captured ALU flags. Presents one entry per cycle to the memory stage over a valid/ready handshake, with stall back-pressure and a flush input for pipeline redirects.

## Interface
- No parameters; data paths are fixed at 32 bits.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  execute stage presents an entry
- `in_ready`  out  1  stage accepts the entry this cycle
- `in_pc`  in  32  instruction PC
- `in_result`  in  32  ALU Result
- `in_zero`, `in_carry`, `in_overflow`  in  1 each  ALU flags
- `in_store_data`  in  32  rs2 value for stores
- `in_rd`  in  5  destination register
- `in_funct3`  in  3  instruction funct3 (branch condition / access size)
- `in_reg_write`, `in_mem_read`, `in_mem_write`, `in_is_branch`  in  1 each  control
- `flush`  in  1  kill all held and incoming entries
- `out_valid`  out  1  entry available to memory stage
- `out_ready`  in  1  memory stage consumes entry
- `out_pc`, `out_result`, `out_store_data`  out  32 each  registered payload
- `out_rd`  out  5; `out_funct3`  out  3
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each
- `out_zero`, `out_carry`, `out_overflow`  out  1 each
- `out_branch_taken`  out  1  resolved branch decision

## Operation
- Transfer in: `in_valid && in_ready`; transfer out: `out_valid && out_ready`.
- Payload captured unmodified except `branch_taken`, computed from inputs at capture and gated by `in_is_branch`:
  - funct3 000 (BEQ, ALU did SUB): `in_zero`; 001 (BNE): `!in_zero`
  - 100/110 (BLT/BLTU, ALU did SLT/SLTU): `in_result[0]`; 101/111 (BGE/BGEU): `!in_result[0]`
  - 010/011: 0
- `branch_taken` never set when `in_is_branch`=0.
- `flush`: next cycle `out_valid`=0, all held entries discarded, same-cycle input dropped. Flush overrides a simultaneous input transfer and output transfer.
- Entries leave strictly in arrival order; none dropped or duplicated except by flush.

## Timing
- Reset (`rst_n`=0 at edge): `out_valid`=0, all payload outputs 0, `out_branch_taken`=0, storage empty. `in_ready`=1 from the first cycle after reset.
- Latency: an entry accepted at edge N is on outputs after edge N, `out_valid`=1 in cycle N+1.
- Throughput: one entry per cycle while `out_ready`=1.
- `out_*` payload held stable while `out_valid && !out_ready`.
- Reset mid-operation: same as power-on reset; held entries lost.

## Configuration
- `EX_MEM_SKID_EN` defined: 2-entry storage (main + skid).
  - `in_ready` is a register output meaning "skid empty", with no combinational path from `out_ready`.
  - An entry accepted while main is stalled goes to skid; `in_ready` drops the next cycle.
  - When main drains, skid moves to main and `in_ready` returns to 1.
  - Full throughput is sustained across stall release.
- `EX_MEM_SKID_EN` undefined: single register.
  - `in_ready = !out_valid || out_ready` (combinational).
  - Load and drain can occur in the same cycle.
  - Functionally identical ordering and latency.

## Test plan
- Reset → `out_valid`=0, `out_result`=0, `in_ready`=1. Then push `in_result`=0x0000_1234, `rd`=5, `reg_write`=1 → next cycle `out_valid`=1 with identical fields.
- Branch resolution, each with `is_branch`=1:
  - funct3=000, `zero`=1 → `branch_taken`=1
  - funct3=001, `zero`=1 → 0
  - funct3=101, `result`=0 → 1
  - funct3=110, `result`=1 → 1
  - `is_branch`=0 with funct3=000, `zero`=1 → 0
- Back-pressure:
  - Stream values 1,2,3,4 with `out_ready` low for 3 cycles mid-stream → output sequence exactly 1,2,3,4, payload stable while stalled.
  - With `EX_MEM_SKID_EN`: `in_ready` low exactly while 2 entries are held.
- Flush with two entries held (skid build) plus `in_valid`=1 on the same cycle → next cycle `out_valid`=0, `in_ready`=1; a later push of 0xA5 emerges alone.
- Full-rate stream of 100 entries with `out_ready`=1 → 100 outputs on consecutive cycles, 1-cycle latency, none dropped.
- Assert `rst_n`=0 while stalled with data held → next cycle `out_valid`=0, all outputs 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, flags and control, resolves branches,
// hands entries to MEM over valid/ready. Define EX_MEM_SKID_EN for a registered-ready skid buffer.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_result,
    input  logic        in_zero,
    input  logic        in_carry,
    input  logic        in_overflow,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_is_branch,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_zero,
    output logic        out_carry,
    output logic        out_overflow,
    output logic        out_branch_taken
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        zero;
        logic        carry;
        logic        overflow;
        logic        branch_taken;
    } entry_t;

    // For BLT/BGE the ALU ran SLT/SLTU, so result[0] carries the less-than outcome.
    function automatic logic resolve_branch(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'b000:          resolve_branch = z;
            3'b001:          resolve_branch = !z;
            3'b100, 3'b110:  resolve_branch = lt;
            3'b101, 3'b111:  resolve_branch = !lt;
            default:         resolve_branch = 1'b0;
        endcase
    endfunction

    entry_t in_entry;
    entry_t main_q, main_d;
    logic   main_vld_q, main_vld_d;

    always_comb begin
        in_entry              = '0;
        in_entry.pc           = in_pc;
        in_entry.result       = in_result;
        in_entry.store_data   = in_store_data;
        in_entry.rd           = in_rd;
        in_entry.funct3       = in_funct3;
        in_entry.reg_write    = in_reg_write;
        in_entry.mem_read     = in_mem_read;
        in_entry.mem_write    = in_mem_write;
        in_entry.zero         = in_zero;
        in_entry.carry        = in_carry;
        in_entry.overflow     = in_overflow;
        in_entry.branch_taken = in_is_branch && resolve_branch(in_funct3, in_zero, in_result[0]);
    end

`ifdef EX_MEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;

    assign in_ready = !skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // Skid full implies main full and in_ready low; only a drain can move things.
            if (out_ready) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || out_ready) begin
            main_vld_d = in_valid;
            if (in_valid) main_d = in_entry;
        end else if (in_valid) begin
            skid_d     = in_entry;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign in_ready = !main_vld_q || out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (in_valid && in_ready) begin
            main_d     = in_entry;
            main_vld_d = 1'b1;
        end else if (out_ready) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end
`endif

    assign out_valid        = main_vld_q;
    assign out_pc           = main_q.pc;
    assign out_result       = main_q.result;
    assign out_store_data   = main_q.store_data;
    assign out_rd           = main_q.rd;
    assign out_funct3       = main_q.funct3;
    assign out_reg_write    = main_q.reg_write;
    assign out_mem_read     = main_q.mem_read;
    assign out_mem_write    = main_q.mem_write;
    assign out_zero         = main_q.zero;
    assign out_carry        = main_q.carry;
    assign out_overflow     = main_q.overflow;
    assign out_branch_taken = main_q.branch_taken;

endmodule
